// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode and FSM state types shared by the sequential ALU
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_SLT  = 3'd4,
    OP_ADDA = 3'd5,
    OP_ANDA = 3'd6,
    OP_ORA  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic is_acc_op(input op_e op);
    return (op == OP_ADDA) || (op == OP_ANDA) || (op == OP_ORA);
  endfunction

endpackage

// File: rtl/alu_seq_dp.sv
// rtl/alu_seq_dp.sv - combinational ALU datapath (A, B, op -> result, carry, zero)
// Optional saturation of ADD/ADDA is selected by defining ALU_SAT_EN.
module alu_seq_dp
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  op_e              i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cf,
  output logic             o_zf
);

  logic [WIDTH:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};

  always_comb begin
    o_result = '0;
    o_cf     = 1'b0;
    case (i_op)
      OP_ADD, OP_ADDA: begin
        o_cf = w_sum[WIDTH];
`ifdef ALU_SAT_EN
        o_result = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
        o_result = w_sum[WIDTH-1:0];
`endif
      end
      OP_AND, OP_ANDA: o_result = i_a & i_b;
      OP_OR,  OP_ORA:  o_result = i_a | i_b;
      OP_SLT:          o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      default: begin
        o_result = '0;
        o_cf     = 1'b0;
      end
    endcase
  end

  assign o_zf = (o_result == '0);

endmodule

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - handshaked sequential ALU: IDLE/EXEC/RESP FSM, operand latches, accumulator
// Saturating ADD/ADDA when ALU_SAT_EN is defined (handled in alu_seq_dp).
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_opcode,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_results,
  output logic             o_cf,
  output logic             o_zf,
  output logic [WIDTH-1:0] o_acc
);

  state_e           r_state;
  state_e           w_next_state;
  op_e              r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_results;
  logic             r_cf;
  logic             r_zf;
  logic [WIDTH-1:0] r_acc;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_result;
  logic             w_cf;
  logic             w_zf;
  logic             w_accept;
  logic             w_exec_done;

  // Accumulating ops take the accumulator as their A operand.
  assign w_a         = is_acc_op(r_op) ? r_acc : r_a;
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_exec_done = (r_state == S_EXEC) && i_enable;

  alu_seq_dp #(.WIDTH(WIDTH)) u_dp (
    .i_a      (w_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_result),
    .o_cf     (w_cf),
    .o_zf     (w_zf)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_EXEC;
      S_EXEC:  if (i_enable) w_next_state = S_RESP;
      S_RESP:  if (i_out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      S_IDLE:  o_in_ready  = i_enable;
      S_RESP:  o_out_valid = 1'b1;
      default: begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op      <= OP_NOP;
      r_a       <= '0;
      r_b       <= '0;
      r_results <= '0;
      r_cf      <= 1'b0;
      r_zf      <= 1'b0;
      r_acc     <= ACC_INIT;
    end else begin
      if (w_accept) begin
        r_op <= op_e'(i_opcode);
        r_a  <= i_data_a;
        r_b  <= i_data_b;
      end
      if (w_exec_done) begin
        r_results <= w_result;
        r_cf      <= w_cf;
        r_zf      <= w_zf;
        if (is_acc_op(r_op)) r_acc <= w_result;
      end
    end
  end

  assign o_results = r_results;
  assign o_cf      = r_cf;
  assign o_zf      = r_zf;
  assign o_acc     = r_acc;

endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - self-checking bench for alu_seq_core (model + directed vectors)
module tb_alu_seq_core;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   opcode;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] results;
  logic         cf;
  logic         zf;
  logic [W-1:0] acc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         cf;
    logic         zf;
    logic [W-1:0] acc;
  } exp_t;

  exp_t        q[$];
  int unsigned m_acc = 0;

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(W), .ACC_INIT('0)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_opcode    (opcode),
    .i_data_a    (data_a),
    .i_data_b    (data_b),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_results   (results),
    .o_cf        (cf),
    .o_zf        (zf),
    .o_acc       (acc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: what a transaction must produce, given the model accumulator.
  function automatic exp_t model(input int op, input int unsigned a, input int unsigned b);
    exp_t        e;
    int unsigned av;
    int unsigned s;
    int unsigned r;
    logic        c;
    av = (op >= 5) ? m_acc : a;
    c  = 1'b0;
    r  = 0;
    case (op)
      1, 5: begin
        s = av + b;
        c = (s >= 65536);
        r = s % 65536;
`ifdef ALU_SAT_EN
        if (c) r = 65535;
`endif
      end
      2, 6: r = av & b;
      3, 7: r = av | b;
      4:    r = (av < b) ? 1 : 0;
      default: r = 0;
    endcase
    if (op >= 5) m_acc = r;
    e.res = r[W-1:0];
    e.cf  = c;
    e.zf  = (r == 0);
    e.acc = m_acc[W-1:0];
    return e;
  endfunction

  // Compare process: every RESP cycle is checked against the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = q[0];
          chk("results", results, e.res);
          chk("cf", cf, e.cf);
          chk("zf", zf, e.zf);
          chk("acc", acc, e.acc);
          chk("in_ready_in_resp", in_ready, 0);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input int op, input int unsigned a, input int unsigned b);
    bit ok;
    ok       = 0;
    opcode   = op[2:0];
    data_a   = a[W-1:0];
    data_b   = b[W-1:0];
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) q.push_back(model(op, a, b));
    else chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 0, 1);
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] held;
    bit           seen;
    rst_n     = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = 3'd0;
    data_a    = '0;
    data_b    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_results", results, 0);
    chk("rst_cf", cf, 0);
    chk("rst_zf", zf, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", acc, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 1);

    // ADD wrap/carry with literal pins and one-EXEC-cycle latency
    send(1, 16'hFFFF, 16'h0001);
    @(negedge clk);
    chk("lat_exec_no_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_resp_valid", out_valid, 1);
`ifdef ALU_SAT_EN
    chk("add_sat_res", results, 16'hFFFF);
    chk("add_sat_zf", zf, 0);
`else
    chk("add_wrap_res", results, 16'h0000);
    chk("add_wrap_zf", zf, 1);
`endif
    chk("add_carry_cf", cf, 1);
    wait_done();

    // Accumulator chain
    send(5, 16'hDEAD, 5);
    wait_done();
    send(5, 0, 7);
    wait_done();
    chk("acc_after_adda", acc, 12);
    send(7, 0, 16'h0100);
    wait_done();
    chk("acc_after_ora", acc, 16'h010C);

    // Reset mid-EXEC of ADDA: no writeback
    send(5, 0, 16'h0020);
    rst_n = 1'b0;
    #1;
    q.delete();
    m_acc = 0;
    chk("midreset_acc", acc, 0);
    chk("midreset_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("postreset_acc", acc, 0);
      chk("postreset_out_valid", out_valid, 0);
      chk("postreset_in_ready", in_ready, 1);
    end
    @(posedge clk);
    #1;

    // SLT
    send(4, 3, 9);
    wait_done();
    chk("slt_lt", results, 1);
    chk("slt_lt_cf", cf, 0);
    send(4, 9, 3);
    wait_done();
    chk("slt_ge", results, 0);
    chk("slt_ge_cf", cf, 0);

    // Backpressure in RESP
    out_ready = 1'b0;
    send(1, 16'h1234, 16'h0001);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    chk("bp_reach_resp", seen, 1);
    held = results;
    chk("bp_value", held, 16'h1235);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_held", out_valid, 1);
      chk("bp_results_held", results, held);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_results_kept", results, 16'h1235);

    // Enable low during EXEC stalls the FSM
    send(2, 16'hF0F0, 16'h3C3C);
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 0);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    enable = 1'b1;
    wait_done();
    chk("and_res", results, 16'h3030);

    // Enable low in IDLE: no accept
    enable   = 1'b0;
    in_valid = 1'b1;
    opcode   = 3'd1;
    repeat (3) begin
      @(negedge clk);
      chk("noacc_in_ready", in_ready, 0);
      chk("noacc_out_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    enable   = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("noacc_idle", in_ready, 1);
    end
    @(posedge clk);
    #1;

    // Remaining ops
    send(3, 16'h00F0, 16'h0F00);
    wait_done();
    chk("or_res", results, 16'h0FF0);
    send(0, 16'h1111, 16'h2222);
    wait_done();
    chk("nop_zf", zf, 1);
    chk("nop_acc", acc, 0);
    send(7, 0, 16'h00FF);
    wait_done();
    send(6, 0, 16'h0F0F);
    wait_done();
    chk("anda_acc", acc, 16'h000F);
    send(5, 0, 16'hFFFF);
    wait_done();
    send(1, 16'h7FFF, 16'h0001);
    wait_done();
    chk("add_nocarry", results, 16'h8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
